huffman_dec: RTL and testbench
==============================

// Module: huffman_dec
// PURPOSE
//  Serial Huffman decoder that sits at the receiving end of the Huffman encoder.
//  It loads the 6-entry code table (HC1..HC6 and M1..M6) when the encoder pulses code_valid.
//  It then consumes a bitstream MSB-first, one bit per bit_valid, and emits one symbol index
//  per completed codeword. It also flags any bit sequence that matches no table entry.
// PARAMETERS
//  NSYM  6  number of table entries/symbols (fixed at 6 for this release)
//  CW    8  codeword/mask width in bits; max code length
// PORTS
//  clk         in   1  single clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  code_valid  in   1  1-cycle pulse: HC1..HC6/M1..M6 valid, latch table
//  HC1..HC6    in   8  codeword k, right-aligned (code in LSBs)
//  M1..M6      in   8  mask k, contiguous ones from bit0; length = popcount; 0 = entry unused
//  bit_valid   in   1  bit_in valid this cycle
//  bit_in      in   1  next stream bit, first-sent bit of a code first
//  table_ready out  1  table latched, decoding enabled
//  sym_valid   out  1  1-cycle pulse: sym holds a decoded symbol
//  sym         out  3  decoded symbol index 1..6 (0 when idle)
//  err         out  1  1-cycle pulse: CW bits accumulated with no match
//  sym_cnt     out 16  count of symbols decoded since last table load (saturates at FFFF)
// BEHAVIOUR
//  Reset (async, immediate): table regs=0, acc=0, len=0, state=NOTABLE; all outputs 0.
//  States
//   NOTABLE: bit_valid ignored (no err). code_valid -> LOAD table, go READY.
//   READY:   bit_valid -> acc<={acc[6:0],bit_in}, len<=len+1. Each entry gets a 4-bit
//            length register Lk=popcount(Mk), computed at load.
//  Match rule (on acc_next/len_next): hit_k = (Mk!=0) && (Lk==len_next) && ((acc_next&Mk)==HCk).
//   - One hit -> next cycle: sym_valid=1, sym=k, sym_cnt++. acc/len cleared, so the next bit
//     starts a new code. Latency is 1 clk from the final bit of a code.
//   - Multiple hits (table not prefix-free) -> lowest k wins.
//   - No hit with len_next==CW -> next cycle: err=1, sym=0. acc/len cleared, decoding resumes.
//  sym holds its last value only during the sym_valid cycle; it returns to 0 otherwise.
//  Back-to-back bits are accepted every cycle with no stall; 1-bit codes can decode every cycle.
//  A code_valid while in READY, with or without a partial code:
//   - Table is reloaded; acc/len/sym_cnt are cleared.
//   - The partial code is discarded without err.
//  code_valid and bit_valid in the same cycle: load wins and the bit is dropped.
//  bit_valid low: no state change; a partial code persists indefinitely.
//  sym_cnt saturates at 16'hFFFF; no wrap.
//  table_ready=1 from the cycle after the first load until reset.
// STRUCTURE
//  Shared header huff_defs.v (`include): NSYM, CW, SYM_W=3, STATE encodings (NOTABLE, READY).
//  Shared with the encoder-side huffproc/ctrl.
//  Sub-module huff_match (combinational, one instance):
//   - Inputs: acc_next, len_next, 6x{HC,M,L}.
//   - Outputs: hit, hit_idx (priority-encoded).
//  Top holds the table regs, shift register, FSM and counters.
// TESTING
//  Table used unless stated (HC/M hex):
//   1={00,01}, 2={02,03}, 3={06,07}, 4={0E,0F}, 5={1E,1F}, 6={1F,1F}.
//  1. Reset mid-stream after bits 1,1 -> all outputs 0 at once, table_ready=0, later bits ignored.
//  2. Load table; bits 0,1,0,1,1,0 on consecutive clks ->
//     sym_valid at clk+1, +3, +6 with sym=1,2,3; sym_cnt=3.
//  3. Bits 1,1,1,1,1 then 1,1,1,1,0 -> sym=6 then sym=5; no err.
//  4. Table with only entry 1={00,01} (others M=0); eight 1-bits ->
//     err pulse 1 clk after 8th bit, sym_valid never; then bit 0 -> sym=1.
//  5. Bits 1,1 then code_valid with same-cycle bit_valid=1 ->
//     no err/sym, acc cleared, sym_cnt=0; then bit 0 -> sym=1.
//  6. bit_valid gaps: 1,(idle 3 clks),0 -> sym=2 one clk after the 0; bits before first load ignored.

Source files
------------

// File: rtl/huffman_dec_pkg.sv
// Shared constants, types and helpers for the serial Huffman decoder.
// State encodings stay compatible with the encoder-side controller.
package huffman_dec_pkg;

  localparam int NSYM  = 6;
  localparam int CW    = 8;
  localparam int SYM_W = 3;
  localparam int LEN_W = 4;

  localparam logic [0:0] NOTABLE = 1'b0;
  localparam logic [0:0] READY   = 1'b1;

  typedef logic [CW-1:0]    code_t;
  typedef logic [LEN_W-1:0] len_t;

  function automatic len_t popcount(input code_t v);
    len_t cnt;
    cnt = '0;
    for (int i = 0; i < CW; i++) begin
      cnt = cnt + len_t'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/huffman_dec_match.sv
// Combinational table lookup: compares the candidate code against all entries.
// Several hits can occur with a non prefix-free table; the lowest index wins.
module huffman_dec_match
  import huffman_dec_pkg::*;
(
  input  code_t [NSYM-1:0]  hc,
  input  code_t [NSYM-1:0]  m,
  input  len_t  [NSYM-1:0]  l,
  input  code_t             acc_next,
  input  len_t              len_next,
  output logic              hit,
  output logic [SYM_W-1:0]  hit_idx
);

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    // Scan from the top down so the lowest matching entry is written last.
    for (int k = NSYM - 1; k >= 0; k--) begin
      if ((m[k] != '0) && (l[k] == len_next) && ((acc_next & m[k]) == hc[k])) begin
        hit     = 1'b1;
        hit_idx = SYM_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/huffman_dec.sv
// Serial Huffman decoder: latches a 6-entry code table, then shifts in one bit per
// bit_valid and emits the symbol index (or an error) one clock after the final bit.
module huffman_dec
  import huffman_dec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        table_ready,
  output logic        sym_valid,
  output logic [2:0]  sym,
  output logic        err,
  output logic [15:0] sym_cnt
);

  logic [0:0]        state;
  code_t [NSYM-1:0]  hc_q;
  code_t [NSYM-1:0]  m_q;
  len_t  [NSYM-1:0]  l_q;
  code_t             acc;
  len_t              len;

  code_t             acc_next;
  len_t              len_next;
  logic              hit;
  logic [SYM_W-1:0]  hit_idx;

  code_t [NSYM-1:0]  hc_in;
  code_t [NSYM-1:0]  m_in;

  assign hc_in = {HC6, HC5, HC4, HC3, HC2, HC1};
  assign m_in  = {M6, M5, M4, M3, M2, M1};

  assign acc_next = {acc[CW-2:0], bit_in};
  assign len_next = len + len_t'(1);

  huffman_dec_match u_match (
    .hc       (hc_q),
    .m        (m_q),
    .l        (l_q),
    .acc_next (acc_next),
    .len_next (len_next),
    .hit      (hit),
    .hit_idx  (hit_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= NOTABLE;
      hc_q        <= '0;
      m_q         <= '0;
      l_q         <= '0;
      acc         <= '0;
      len         <= '0;
      table_ready <= 1'b0;
      sym_valid   <= 1'b0;
      sym         <= '0;
      err         <= 1'b0;
      sym_cnt     <= '0;
    end else begin
      sym_valid <= 1'b0;
      sym       <= '0;
      err       <= 1'b0;
      if (code_valid) begin
        // A reload drops any partial code silently; a same-cycle bit is lost.
        state       <= READY;
        table_ready <= 1'b1;
        hc_q        <= hc_in;
        m_q         <= m_in;
        for (int k = 0; k < NSYM; k++) begin
          l_q[k] <= popcount(m_in[k]);
        end
        acc     <= '0;
        len     <= '0;
        sym_cnt <= '0;
      end else if (state == READY && bit_valid) begin
        if (hit) begin
          sym_valid <= 1'b1;
          sym       <= hit_idx;
          acc       <= '0;
          len       <= '0;
          if (sym_cnt != 16'hFFFF) begin
            sym_cnt <= sym_cnt + 16'd1;
          end
        end else if (len_next == len_t'(CW)) begin
          err <= 1'b1;
          acc <= '0;
          len <= '0;
        end else begin
          acc <= acc_next;
          len <= len_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_dec.sv
// Self-checking bench for huffman_dec: a behavioural model queues expected outputs
// per driven cycle, and each entry is popped and compared just after the clock edge.
module tb_huffman_dec;

  logic        clk = 1'b0;
  logic        reset;
  logic        code_valid;
  logic        bit_valid;
  logic        bit_in;
  logic [7:0]  tb_hc [6];
  logic [7:0]  tb_m  [6];
  logic        table_ready;
  logic        sym_valid;
  logic [2:0]  sym;
  logic        err;
  logic [15:0] sym_cnt;

  always #5 clk = ~clk;

  huffman_dec dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .HC1         (tb_hc[0]),
    .HC2         (tb_hc[1]),
    .HC3         (tb_hc[2]),
    .HC4         (tb_hc[3]),
    .HC5         (tb_hc[4]),
    .HC6         (tb_hc[5]),
    .M1          (tb_m[0]),
    .M2          (tb_m[1]),
    .M3          (tb_m[2]),
    .M4          (tb_m[3]),
    .M5          (tb_m[4]),
    .M6          (tb_m[5]),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .table_ready (table_ready),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .err         (err),
    .sym_cnt     (sym_cnt)
  );

  typedef struct packed {
    logic        tr;
    logic        sv;
    logic [2:0]  sy;
    logic        er;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: table as latched, accumulated bits, and symbol count.
  logic [7:0] mdl_hc [6];
  logic [7:0] mdl_m  [6];
  logic       mdl_ready;
  int         mdl_acc;
  int         mdl_len;
  int         mdl_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model_step(input logic cv, input logic bv, input logic b);
    exp_t e;
    e = '0;
    if (cv) begin
      for (int k = 0; k < 6; k++) begin
        mdl_hc[k] = tb_hc[k];
        mdl_m[k]  = tb_m[k];
      end
      mdl_ready = 1'b1;
      mdl_acc = 0;
      mdl_len = 0;
      mdl_cnt = 0;
    end else if (mdl_ready && bv) begin
      int found;
      found = 0;
      mdl_acc = mdl_acc * 2 + int'(b);
      mdl_len = mdl_len + 1;
      for (int k = 0; k < 6; k++) begin
        if (found == 0 && mdl_m[k] != 8'h00 && $countones(mdl_m[k]) == mdl_len
            && mdl_acc == int'(mdl_hc[k]))
          found = k + 1;
      end
      if (found != 0) begin
        e.sv = 1'b1;
        e.sy = 3'(found);
        if (mdl_cnt < 65535) mdl_cnt = mdl_cnt + 1;
        mdl_acc = 0;
        mdl_len = 0;
      end else if (mdl_len == 8) begin
        e.er = 1'b1;
        mdl_acc = 0;
        mdl_len = 0;
      end
    end
    e.tr  = mdl_ready;
    e.cnt = 16'(mdl_cnt);
    return e;
  endfunction

  task automatic step(input logic cv, input logic bv, input logic b, input string tag);
    exp_t e;
    @(negedge clk);
    code_valid = cv;
    bit_valid  = bv;
    bit_in     = b;
    exp_q.push_back(model_step(cv, bv, b));
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_tr"},  32'(table_ready), 32'(e.tr));
      check({tag, "_sv"},  32'(sym_valid),   32'(e.sv));
      check({tag, "_sym"}, 32'(sym),         32'(e.sy));
      check({tag, "_err"}, 32'(err),         32'(e.er));
      check({tag, "_cnt"}, 32'(sym_cnt),     32'(e.cnt));
    end
  endtask

  task automatic bits(input logic [31:0] v, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, v[i], tag);
  endtask

  task automatic default_table();
    logic [7:0] h [6];
    h = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
    for (int k = 0; k < 6; k++) begin
      tb_hc[k] = h[k];
    end
    tb_m = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_tr"},  32'(table_ready), 32'd0);
    check({tag, "_sv"},  32'(sym_valid),   32'd0);
    check({tag, "_sym"}, 32'(sym),         32'd0);
    check({tag, "_err"}, 32'(err),         32'd0);
    check({tag, "_cnt"}, 32'(sym_cnt),     32'd0);
    mdl_ready = 1'b0;
    mdl_acc = 0;
    mdl_len = 0;
    mdl_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      mdl_hc[k] = 8'h00;
      mdl_m[k]  = 8'h00;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    code_valid = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    default_table();
    mdl_ready = 1'b0;
    mdl_acc = 0;
    mdl_len = 0;
    mdl_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      mdl_hc[k] = 8'h00;
      mdl_m[k]  = 8'h00;
    end
    #12;
    check("rst_tr",  32'(table_ready), 32'd0);
    check("rst_sv",  32'(sym_valid),   32'd0);
    check("rst_cnt", 32'(sym_cnt),     32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Bits before the first load are ignored, including a 0 that would be symbol 1.
    bits(32'b10110, 5, "preload");

    // Symbol sequence 1,2,3 from 0 10 110.
    step(1'b1, 1'b0, 1'b0, "load");
    bits(32'b010110, 6, "t2");
    check("t2_total", 32'(sym_cnt), 32'd3);

    // 11111 -> 6, 11110 -> 5.
    bits(32'b1111111110, 10, "t3");

    // Reset with a decoded symbol counted and a partial code pending.
    bits(32'b011, 3, "t1pre");
    async_reset("t1");
    bits(32'b0101, 4, "t1post");

    // Single-entry table: eight ones give err, then 0 gives symbol 1.
    tb_m = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    step(1'b1, 1'b0, 1'b0, "load4");
    bits(32'hFF, 8, "t4");
    bits(32'b0, 1, "t4b");

    // Reload with a partial code and a same-cycle bit that must be dropped.
    default_table();
    step(1'b1, 1'b0, 1'b0, "load5");
    bits(32'b0, 1, "t5a");
    bits(32'b11, 2, "t5b");
    step(1'b1, 1'b1, 1'b1, "t5load");
    check("t5_cnt0", 32'(sym_cnt), 32'd0);
    bits(32'b0, 1, "t5c");

    // Partial code survives idle cycles.
    bits(32'b1, 1, "t6a");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "t6idle");
    bits(32'b0, 1, "t6b");

    // Non prefix-free table: entry 2 and entry 4 both match 10; lowest wins.
    tb_hc = '{8'h03, 8'h02, 8'h00, 8'h02, 8'h00, 8'h00};
    tb_m  = '{8'h03, 8'h03, 8'h00, 8'h03, 8'h00, 8'h00};
    step(1'b1, 1'b0, 1'b0, "load7");
    bits(32'b1011, 4, "t7");

    // Random stream with random idle gaps against the default table.
    default_table();
    step(1'b1, 1'b0, 1'b0, "load8");
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
